// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit (MIPS-style mult, multu, div, divu).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin an operation; accepted only in IDLE or FINISH
//   op           00 mult, 01 multu, 10 div, 11 divu
//   a, b         operands (rs, rt); captured on the accepting edge
//   busy         high while the FSM is in CALC
//   done         one-cycle pulse (FSM in FINISH) when hi/lo/div_by_zero were updated
//   hi, lo       product {hi, lo}, or remainder (hi) / quotient (lo)
//   div_by_zero  set with done when a divide had b == 0; held until the next done
//
// Handshake: start is a request sampled on each rising edge. It is honoured only
// while busy is low (IDLE or FINISH); while busy is high it is ignored. Each
// accepted request produces exactly one done pulse unless reset intervenes.
//
// Configuration: define MULDIV_EARLY_OUT_EN to let multiply leave CALC as soon
// as the remaining multiplier magnitude is zero. Divide latency is unaffected.

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated
    logic               dbz_pend;
    logic [WIDTH-1:0]   a_raw;     // unmodified dividend, returned in hi on divide by zero
    logic [2*WIDTH-1:0] acc;       // mult: running product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;     // mult: multiplicand shifted left one place per cycle
    logic [WIDTH-1:0]   mplr;      // mult: multiplier shifted right; div: divisor
    logic [CW-1:0]      cnt;

    // Combinational signals
    logic               signed_op, a_neg, b_neg, accept, last, mul_last, calc_end;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, res_hi, res_lo;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] acc_mul, acc_div, acc_next, prod_fix;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        // Most-negative operand maps to 2^(WIDTH-1), which is correct as unsigned.
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        accept    = start && (state == IDLE || state == FINISH);

        // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
        acc_mul   = mplr[0] ? (acc + mcand) : acc;

        // Restoring step: bring in the next dividend bit, keep the difference if non-negative.
        shifted   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = shifted - {1'b0, mplr};
        acc_div   = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

        acc_next  = is_div ? acc_div : acc_mul;

        last      = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        // Nothing left to add once the bits above the one consumed this cycle are zero.
        mul_last  = last || (mplr[WIDTH-1:1] == '0);
`else
        mul_last  = last;
`endif
        calc_end  = is_div ? last : mul_last;

        // Sign correction applied to the final iteration's result.
        prod_fix  = neg_res ? -acc_next : acc_next;
        q_mag     = acc_next[WIDTH-1:0];
        r_mag     = acc_next[2*WIDTH-1:WIDTH];
        res_lo    = is_div ? (neg_res ? -q_mag : q_mag) : prod_fix[WIDTH-1:0];
        res_hi    = is_div ? (neg_rem ? -r_mag : r_mag) : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_pend    <= 1'b0;
            a_raw       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplr        <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (accept) begin
                        state    <= CALC;
                        is_div   <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        dbz_pend <= op[1] && (b == '0);
                        a_raw    <= a;
                        mplr     <= b_mag;
                        cnt      <= '0;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (dbz_pend) begin
                        state       <= FINISH;
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (!is_div) begin
                            mcand <= mcand << 1;
                            mplr  <= mplr >> 1;
                        end
                        if (calc_end) begin
                            state       <= FINISH;
                            hi          <= res_hi;
                            lo          <= res_lo;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH = 32).
// Directed vector table, hand-written multi-cycle sequences (ignored start,
// back-to-back, reset mid-operation) and randomized operations checked against
// a plain-arithmetic reference model.

module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int mag_bits(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic void model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] ehi, output logic [W-1:0] elo,
                                  output logic edbz, output int elat);
        longint      sp, sa, sb, sq, sr;
        logic [63:0] up;
        logic [W-1:0] bm;
        edbz = 1'b0;
        elat = W + 1;
        ehi  = '0;
        elo  = '0;
        case (mop)
            2'b00: begin
                sp = longint'($signed(ma)) * longint'($signed(mb));
                up = sp;
                ehi = up[63:32]; elo = up[31:0];
            end
            2'b01: begin
                up = {32'b0, ma} * {32'b0, mb};
                ehi = up[63:32]; elo = up[31:0];
            end
            default: begin
                if (mb == '0) begin
                    edbz = 1'b1; ehi = ma; elo = '1; elat = 2;
                end else if (mop == 2'b10) begin
                    sa = longint'($signed(ma)); sb = longint'($signed(mb));
                    sq = sa / sb; sr = sa % sb;
                    up = sq; elo = up[31:0];
                    up = sr; ehi = up[31:0];
                end else begin
                    elo = ma / mb; ehi = ma % mb;
                end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!mop[1]) begin
            bm = (mop == 2'b00 && mb[W-1]) ? -mb : mb;
            elat = ((mag_bits(bm) < 1) ? 1 : mag_bits(bm)) + 1;
        end
`else
        bm = mb;
        if (mag_bits(bm) < 0) elat = 0;
`endif
    endfunction

    // ---------------- drivers ----------------
    // Called at a negedge: present a request, let the next posedge take it, then scramble inputs.
    task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    endtask

    // Returns at the negedge where done is seen; cyc counts cycles since the accepting edge.
    task automatic wait_done(output int cyc, output int busy_cyc, output logic first_busy);
        cyc = 0; busy_cyc = 0; first_busy = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_busy = busy;
            if (busy) busy_cyc++;
        end while (!done && cyc < 200);
        if (!done) begin
            n_total++;
            $display("FAIL timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [W-1:0] ehi, elo;
        logic edbz, fb;
        int elat, cyc, bc;
        model(iop, ia, ib, ehi, elo, edbz, elat);
        issue(iop, ia, ib);
        wait_done(cyc, bc, fb);
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
        chk({name, " dbz"}, 64'(div_by_zero), 64'(edbz));
        chk({name, " latency"}, 64'(cyc), 64'(elat));
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] ehi, elo, ra, rb;
        logic edbz, fb;
        int elat, cyc, bc;
        logic [1:0] rop;

        // Directed table: {op, a, b, hi, lo, dbz, latency}
        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[5] = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
        vecs[6] = '{2'b11, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 33};
`ifdef MULDIV_EARLY_OUT_EN
        vecs[1].lat = 4;
        vecs[0].lat = 33;
`endif

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- directed table ----
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(cyc, bc, fb);
            chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("vec%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
            chk($sformatf("vec%0d latency", i), 64'(cyc), 64'(vecs[i].lat));
            chk($sformatf("vec%0d busy cycles", i), 64'(bc), 64'(vecs[i].lat - 1));
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
        end

        // ---- ignored start during CALC ----
        model(2'b01, 32'h12345678, 32'h9ABCDEF0, ehi, elo, edbz, elat);
        issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        cyc = 10;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignored start hi", 64'(hi), 64'(ehi));
        chk("ignored start lo", 64'(lo), 64'(elo));
        chk("ignored start latency", 64'(cyc), 64'(elat));
        @(negedge clk);
        chk("ignored start no restart", 64'(busy), 64'd0);

        // ---- back-to-back: start held in FINISH ----
        issue(2'b11, 32'd1000, 32'd7);
        wait_done(cyc, bc, fb);
        chk("b2b first lo", 64'(lo), 64'd142);
        chk("b2b first hi", 64'(hi), 64'd6);
        model(2'b00, 32'hFFFFFF00, 32'h00000100, ehi, elo, edbz, elat);
        issue(2'b00, 32'hFFFFFF00, 32'h00000100);
        chk("b2b done still pulses", 64'(done), 64'd0);
        wait_done(cyc, bc, fb);
        chk("b2b busy next cycle", 64'(fb), 64'd1);
        chk("b2b second hi", 64'(hi), 64'(ehi));
        chk("b2b second lo", 64'(lo), 64'(elo));
        chk("b2b second latency", 64'(cyc), 64'(elat));
        @(negedge clk);

        // ---- reset mid-operation ----
        issue(2'b10, 32'hFFFF0000, 32'd3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        bc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) bc++;
        end
        rst_n = 1'b1;
        repeat (35) begin
            @(negedge clk);
            if (done) bc++;
        end
        chk("midreset no done", 64'(bc), 64'd0);
        run_check("after reset", 2'b10, 32'hFFFFFF9C, 32'd7);
        @(negedge clk);

        // ---- randomized against model ----
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'h80000000 | 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_check($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL global timeout");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $finish;
    end

endmodule
